// File: rtl/pong_pkg.sv
// Shared Pong datapath constants and types: matrix geometry, paddle position,
// quadrature state encoding and the encoder channel FSM states.
package pong_pkg;

  localparam int ROWS     = 64;
  localparam int PADDLE_H = 8;
  localparam int YMAX     = ROWS - PADDLE_H;

  typedef logic [5:0] pos_t;

  // Gray-coded quadrature states in forward (paddle-down) order.
  localparam logic [1:0] QUAD_S0 = 2'b00;
  localparam logic [1:0] QUAD_S1 = 2'b01;
  localparam logic [1:0] QUAD_S2 = 2'b11;
  localparam logic [1:0] QUAD_S3 = 2'b10;

  typedef logic [0:0] chan_state_t;
  localparam chan_state_t PRIME = 1'b0;
  localparam chan_state_t TRACK = 1'b1;

  // Maps a quadrature state to its phase index so a forward move is +1 mod 4.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] phase;
    case (ab)
      QUAD_S0: phase = 2'd0;
      QUAD_S1: phase = 2'd1;
      QUAD_S2: phase = 2'd2;
      QUAD_S3: phase = 2'd3;
      default: phase = 2'd0;
    endcase
    return phase;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One player's encoder path: two-flop synchronizer, per-pin debouncer, prime/track
// FSM, quadrature decoder, step accumulator and clamped paddle position.
module quad_channel
  import pong_pkg::*;
#(
  parameter int Y_LIMIT         = pong_pkg::YMAX,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_COUNTS     = 2
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       reset_game,
  input  logic       a,
  input  logic       b,
  output logic [5:0] y,
  output logic       moved,
  output logic       err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ACC_W = $clog2(STEP_COUNTS + 1) + 1;

  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(STEP_COUNTS);
  localparam logic signed [ACC_W-1:0] ACC_BOT = -ACC_TOP;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam pos_t                    Y_TOP   = pos_t'(Y_LIMIT);
  localparam pos_t                    Y_MID   = pos_t'(Y_LIMIT / 2);

  logic [1:0]              sync1;
  logic [1:0]              sync2;
  logic [1:0]              filt;
  logic [1:0]              prev;
  logic [CNT_W-1:0]        deb_cnt [2];
  logic [CNT_W-1:0]        prime_cnt;
  chan_state_t             state;
  logic                    settled;
  logic                    fwd;
  logic                    rev;
  logic                    illegal;
  logic [1:0]              phase_diff;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    req_up;
  logic                    req_dn;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_MAX) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign settled = (sync2 == filt);

  // PRIME adopts whatever the pins settle to as the starting phase, so a
  // power-up position never decodes as movement or as an illegal jump.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state     <= PRIME;
      prev      <= '0;
      prime_cnt <= '0;
    end else if (state == PRIME) begin
      if (!settled) begin
        prime_cnt <= '0;
      end else if (prime_cnt == CNT_MAX) begin
        prev      <= filt;
        state     <= TRACK;
        prime_cnt <= '0;
      end else begin
        prime_cnt <= prime_cnt + CNT_ONE;
      end
    end else begin
      prev <= filt;
    end
  end

  always_comb begin
    fwd        = 1'b0;
    rev        = 1'b0;
    illegal    = 1'b0;
    phase_diff = quad_phase(filt) - quad_phase(prev);
    if (state == TRACK) begin
      case (phase_diff)
        2'd1:    fwd     = 1'b1;
        2'd3:    rev     = 1'b1;
        2'd2:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_next = acc;
    if (fwd)      acc_next = acc + ACC_ONE;
    else if (rev) acc_next = acc - ACC_ONE;
  end

  always_ff @(posedge sys_clock) begin
    if (reset || reset_game) begin
      acc    <= '0;
      req_up <= 1'b0;
      req_dn <= 1'b0;
      err    <= 1'b0;
    end else begin
      err    <= illegal;
      req_up <= 1'b0;
      req_dn <= 1'b0;
      if (acc_next == ACC_TOP) begin
        req_up <= 1'b1;
        acc    <= '0;
      end else if (acc_next == ACC_BOT) begin
        req_dn <= 1'b1;
        acc    <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

  // Requests past either end are dropped rather than wrapped.
  always_ff @(posedge sys_clock) begin
    if (reset || reset_game) begin
      y     <= Y_MID;
      moved <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (req_up && (y != Y_TOP)) begin
        y     <= y + 6'd1;
        moved <= 1'b1;
      end else if (req_dn && (y != 6'd0)) begin
        y     <= y - 6'd1;
        moved <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_encoder.sv
// Pong input stage: turns both players' raw quadrature encoders into clamped
// paddle row positions, with move and illegal-transition pulses.
module paddle_encoder #(
  parameter int ROWS            = pong_pkg::ROWS,
  parameter int PADDLE_H        = pong_pkg::PADDLE_H,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_COUNTS     = 2
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       reset_game,
  input  logic       enc1a,
  input  logic       enc1b,
  input  logic       enc2a,
  input  logic       enc2b,
  output logic [5:0] p1y,
  output logic [5:0] p2y,
  output logic       p1_moved,
  output logic       p2_moved,
  output logic [1:0] enc_err
);

  localparam int Y_LIMIT = ROWS - PADDLE_H;

  logic err1;
  logic err2;

  quad_channel #(
    .Y_LIMIT        (Y_LIMIT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_COUNTS    (STEP_COUNTS)
  ) u_ch1 (
    .sys_clock (sys_clock),
    .reset     (reset),
    .reset_game(reset_game),
    .a         (enc1a),
    .b         (enc1b),
    .y         (p1y),
    .moved     (p1_moved),
    .err       (err1)
  );

  quad_channel #(
    .Y_LIMIT        (Y_LIMIT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_COUNTS    (STEP_COUNTS)
  ) u_ch2 (
    .sys_clock (sys_clock),
    .reset     (reset),
    .reset_game(reset_game),
    .a         (enc2a),
    .b         (enc2b),
    .y         (p2y),
    .moved     (p2_moved),
    .err       (err2)
  );

  assign enc_err = {err2, err1};

endmodule
